// File: rtl/image_fetch_if.sv
// BRAM port-B and pixel-stream bundle for image_fetch.
// master = fetch engine side, slave = memory/sink side.
interface image_fetch_if #(
    parameter int WIDTH = 8
);
    logic [10:0]      addrb;
    logic             enb;
    logic [3:0]       web;
    logic [31:0]      dinb;
    logic [31:0]      doutb;
    logic             pix_valid;
    logic             pix_ready;
    logic [WIDTH-1:0] pix_data;
    logic [9:0]       pix_idx;

    modport master (
        output addrb, enb, web, dinb, pix_valid, pix_data, pix_idx,
        input  doutb, pix_ready
    );

    modport slave (
        input  addrb, enb, web, dinb, pix_valid, pix_data, pix_idx,
        output doutb, pix_ready
    );
endinterface

// File: rtl/image_fetch.sv
// Polls a BRAM mailbox word; when it reads all-ones, streams the packed image
// (last word first) as pixels, then clears the mailbox and pulses frame_done.
module image_fetch #(
    parameter int WIDTH     = 8,
    parameter int PIX_W     = 28,
    parameter int PIX_H     = 28,
    parameter int FLAG_ADDR = 196
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    image_fetch_if.master bus,
    output logic          frame_done,
    output logic          busy
);
    localparam int NWORDS = PIX_W * PIX_H / 4;

    typedef enum logic [2:0] {
        S_IDLE, S_POLL, S_POLL_WAIT, S_RD, S_RD_WAIT, S_EMIT, S_CLEAR, S_DONE
    } state_t;

    state_t           r_state;
    logic [10:0]      r_addrb;
    logic             r_enb;
    logic [3:0]       r_web;
    logic [31:0]      r_dinb;
    logic             r_pix_valid;
    logic [WIDTH-1:0] r_pix_data;
    logic [9:0]       r_pix_idx;
    logic             r_frame_done;
    logic             r_busy;
    logic [10:0]      r_w;
    logic [1:0]       r_lane;
    logic [31:0]      r_hold;

    logic [1:0]       w_next_lane;
    logic [7:0]       w_next_byte;

    always_comb begin
        w_next_lane = r_lane + 2'd1;
        w_next_byte = r_hold[8*w_next_lane +: 8];
    end

    // Outputs are loaded on the edge entering each state, so they are valid
    // for the whole cycle spent in that state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_addrb      <= '0;
            r_enb        <= 1'b0;
            r_web        <= '0;
            r_dinb       <= '0;
            r_pix_valid  <= 1'b0;
            r_pix_data   <= '0;
            r_pix_idx    <= '0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
            r_w          <= '0;
            r_lane       <= '0;
            r_hold       <= '0;
        end else begin
            r_enb        <= 1'b0;
            r_web        <= '0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_state <= S_POLL;
                        r_enb   <= 1'b1;
                        r_addrb <= 11'(FLAG_ADDR);
                        r_busy  <= 1'b1;
                    end
                end
                S_POLL: r_state <= S_POLL_WAIT;
                S_POLL_WAIT: begin
                    if (bus.doutb == '1) begin
                        r_w       <= 11'(NWORDS - 1);
                        r_pix_idx <= '0;
                        r_state   <= S_RD;
                        r_enb     <= 1'b1;
                        r_addrb   <= 11'(NWORDS - 1);
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_RD: r_state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    r_hold      <= bus.doutb;
                    r_lane      <= '0;
                    r_pix_valid <= 1'b1;
                    r_pix_data  <= WIDTH'(bus.doutb[7:0]);
                    r_state     <= S_EMIT;
                end
                S_EMIT: begin
                    if (bus.pix_ready) begin
                        if (r_lane == 2'd3) begin
                            r_pix_valid <= 1'b0;
                            if (r_w == '0) begin
                                r_state <= S_CLEAR;
                                r_enb   <= 1'b1;
                                r_web   <= '1;
                                r_addrb <= 11'(FLAG_ADDR);
                                r_dinb  <= '0;
                            end else begin
                                // Index stays on the last pixel at frame end.
                                r_pix_idx <= r_pix_idx + 10'd1;
                                r_w       <= r_w - 11'd1;
                                r_addrb   <= r_w - 11'd1;
                                r_enb     <= 1'b1;
                                r_state   <= S_RD;
                            end
                        end else begin
                            r_lane     <= w_next_lane;
                            r_pix_data <= WIDTH'(w_next_byte);
                            r_pix_idx  <= r_pix_idx + 10'd1;
                        end
                    end
                end
                S_CLEAR: begin
                    r_state      <= S_DONE;
                    r_frame_done <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.addrb     = r_addrb;
    assign bus.enb       = r_enb;
    assign bus.web       = r_web;
    assign bus.dinb      = r_dinb;
    assign bus.pix_valid = r_pix_valid;
    assign bus.pix_data  = r_pix_data;
    assign bus.pix_idx   = r_pix_idx;
    assign frame_done    = r_frame_done;
    assign busy          = r_busy;
endmodule

// File: tb/tb_image_fetch.sv
// Self-checking bench for image_fetch: BRAM model, pixel monitor, vector table
// and hand-written reset / back-to-back frame sequences.
module tb_image_fetch;
    localparam int NWORDS = 196;
    localparam int NPIX   = 784;
    localparam int FLAG   = 196;

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic frame_done;
    logic busy;

    image_fetch_if #(.WIDTH(8)) bus ();

    image_fetch #(
        .WIDTH(8), .PIX_W(28), .PIX_H(28), .FLAG_ADDR(FLAG)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .bus(bus.master),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0, t_poll = -1, frame_cycles = 0;
    int pix_cnt = 0, done_cnt = 0, poll_cnt = 0, rd_other = 0, wr_cnt = 0;
    int exp_idx = 0, cur_seed = 1;
    bit stall_mode = 0, prev_stall = 0;
    logic [7:0] held_data;
    logic [9:0] held_idx;

    typedef struct {
        bit          en;
        logic [31:0] mbox;
        bit          stall;
        int          cycles;
        int          exp_pix;
        int          exp_done;
        logic [31:0] exp_mbox;
    } vec_t;
    vec_t vecs [6];

    function automatic logic [7:0] img(input int p, input int seed);
        int v;
        v = p * 37 + seed * 101 + (p >> 3);
        return 8'(v ^ 32'h5A);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic load_frame(input int seed, input logic [31:0] flag);
        for (int w = 0; w < 256; w++) mem[w] = '0;
        for (int w = 0; w < NWORDS; w++)
            for (int l = 0; l < 4; l++)
                mem[w][8*l +: 8] = img(4 * (NWORDS - 1 - w) + l, seed);
        mem[FLAG] = flag;
    endtask

    task automatic bram();
        if (bus.enb) begin
            bus.doutb <= mem[bus.addrb[7:0]];
            for (int b = 0; b < 4; b++)
                if (bus.web[b]) mem[bus.addrb[7:0]][8*b +: 8] = bus.dinb[8*b +: 8];
        end
    endtask

    task automatic mon();
        cyc++;
        bus.pix_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        if (prev_stall) begin
            chk("stall_valid", 32'(bus.pix_valid), 32'd1);
            chk("stall_data", 32'(bus.pix_data), 32'(held_data));
            chk("stall_idx", 32'(bus.pix_idx), 32'(held_idx));
        end
        prev_stall = bus.pix_valid && !bus.pix_ready;
        held_data  = bus.pix_data;
        held_idx   = bus.pix_idx;
        if (bus.pix_valid && bus.pix_ready) begin
            if (exp_idx < NPIX) begin
                chk("pix_idx", 32'(bus.pix_idx), 32'(exp_idx));
                chk("pix_data", 32'(bus.pix_data), 32'(img(exp_idx, cur_seed)));
            end else begin
                chk("pix_overrun", 32'(exp_idx), 32'(NPIX - 1));
            end
            exp_idx++;
            pix_cnt++;
        end
        if (bus.web != 4'h0) begin
            wr_cnt++;
            chk("wr_addr", 32'(bus.addrb), 32'(FLAG));
            chk("wr_web", 32'(bus.web), 32'hF);
            chk("wr_data", bus.dinb, 32'h0);
        end
        if (bus.enb && bus.web == 4'h0) begin
            if (bus.addrb == 11'(FLAG)) begin
                poll_cnt++;
                t_poll = cyc;
            end else begin
                rd_other++;
            end
        end
        if (frame_done) begin
            done_cnt++;
            chk("frame_pixels", 32'(exp_idx), 32'(NPIX));
            frame_cycles = cyc - t_poll + 1;
            exp_idx = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        bram();
        @(negedge clk);
        mon();
    endtask

    task automatic clear_counts();
        pix_cnt = 0; done_cnt = 0; poll_cnt = 0; rd_other = 0; wr_cnt = 0;
        exp_idx = 0; prev_stall = 0; frame_cycles = 0; t_poll = -1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_addrb"}, 32'(bus.addrb), 32'h0);
        chk({tag, "_enb"}, 32'(bus.enb), 32'h0);
        chk({tag, "_web"}, 32'(bus.web), 32'h0);
        chk({tag, "_dinb"}, bus.dinb, 32'h0);
        chk({tag, "_pix_valid"}, 32'(bus.pix_valid), 32'h0);
        chk({tag, "_pix_data"}, 32'(bus.pix_data), 32'h0);
        chk({tag, "_pix_idx"}, 32'(bus.pix_idx), 32'h0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        int pc;
        bit hit;
        vecs[0] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 1300, NPIX, 1, 32'h0};
        vecs[1] = '{1'b1, 32'h0000_0000, 1'b0, 40,   0,    0, 32'h0000_0000};
        vecs[2] = '{1'b1, 32'h0000_FFFF, 1'b0, 40,   0,    0, 32'h0000_FFFF};
        vecs[3] = '{1'b1, 32'hFFFF_FFFE, 1'b0, 40,   0,    0, 32'hFFFF_FFFE};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF, 1'b0, 30,   0,    0, 32'hFFFF_FFFF};
        vecs[5] = '{1'b1, 32'hFFFF_FFFF, 1'b1, 3500, NPIX, 1, 32'h0};

        reset = 1'b0;
        en = 1'b0;
        bus.pix_ready = 1'b1;
        bus.doutb = '0;
        load_frame(1, 32'h0);
        repeat (3) step();
        chk_reset_outputs("rst");
        reset = 1'b1;
        repeat (2) step();

        for (int i = 0; i < 6; i++) begin
            load_frame(1, vecs[i].mbox);
            cur_seed = 1;
            clear_counts();
            stall_mode = vecs[i].stall;
            en = vecs[i].en;
            repeat (vecs[i].cycles) step();
            en = 1'b0;
            repeat (6) step();
            stall_mode = 0;
            chk($sformatf("v%0d_pixels", i), 32'(pix_cnt), 32'(vecs[i].exp_pix));
            chk($sformatf("v%0d_done", i), 32'(done_cnt), 32'(vecs[i].exp_done));
            chk($sformatf("v%0d_mbox", i), mem[FLAG], vecs[i].exp_mbox);
            chk($sformatf("v%0d_writes", i), 32'(wr_cnt), 32'(vecs[i].exp_done));
            if (vecs[i].exp_pix == 0) begin
                chk($sformatf("v%0d_data_reads", i), 32'(rd_other), 32'h0);
                if (vecs[i].en) chk($sformatf("v%0d_repeat_polls", i), 32'(poll_cnt >= 2), 32'h1);
                else            chk($sformatf("v%0d_no_polls", i), 32'(poll_cnt), 32'h0);
            end
            if (vecs[i].exp_done != 0 && !vecs[i].stall)
                chk($sformatf("v%0d_frame_cycles", i), 32'(frame_cycles), 32'd1180);
        end

        // Reset mid-frame at pixel 300.
        load_frame(3, 32'hFFFF_FFFF);
        cur_seed = 3;
        clear_counts();
        en = 1'b1;
        hit = 0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            step();
            if (exp_idx == 300) hit = 1;
        end
        chk("reach_pixel_300", 32'(hit), 32'h1);
        @(posedge clk);
        bram();
        #2 reset = 1'b0;
        #1 chk_reset_outputs("midrst");
        chk("midrst_mbox", mem[FLAG], 32'hFFFF_FFFF);
        chk("midrst_writes", 32'(wr_cnt), 32'h0);
        @(negedge clk);
        repeat (2) step();
        clear_counts();
        reset = 1'b1;
        for (int i = 0; i < 1500 && done_cnt < 1; i++) step();
        en = 1'b0;
        repeat (6) step();
        chk("refetch_pixels", 32'(pix_cnt), 32'(NPIX));
        chk("refetch_done", 32'(done_cnt), 32'h1);
        chk("refetch_mbox", mem[FLAG], 32'h0);

        // Two frames back-to-back, second loaded after frame_done.
        load_frame(1, 32'hFFFF_FFFF);
        cur_seed = 1;
        clear_counts();
        en = 1'b1;
        for (int i = 0; i < 1500 && done_cnt < 1; i++) step();
        repeat (20) step();
        pc = poll_cnt;
        load_frame(2, 32'hFFFF_FFFF);
        cur_seed = 2;
        for (int i = 0; i < 1500 && done_cnt < 2; i++) step();
        en = 1'b0;
        repeat (6) step();
        chk("b2b_polls_between", 32'(pc >= 3), 32'h1);
        chk("b2b_pixels", 32'(pix_cnt), 32'(2 * NPIX));
        chk("b2b_done", 32'(done_cnt), 32'h2);
        chk("b2b_mbox", mem[FLAG], 32'h0);
        chk("b2b_idle", 32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
